// File: rtl/id_inst_buffer_pkg.sv
// Shared types and constants for the IF->ID instruction buffer.
// Field widths, reset PC and branch/jump opcode classes.
package id_inst_buffer_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int EXC_W   = 5;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [3:0] OP_BR_HI   = 4'b0001;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               exc;
    logic [EXC_W-1:0]   exccode;
    logic [PC_W-1:0]    vaddr;
    logic               bd;
  } pkt_t;

endpackage

// File: rtl/id_inst_buffer_bj_predecode.sv
// Combinational predecode: flags branch and jump instructions.
// Shared with the decoder's brcal selection.
module bj_predecode
  import id_inst_buffer_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_is_bj
);

  logic [5:0] w_op;
  logic [4:0] w_rt;
  logic [5:0] w_fn;
  logic       w_br;
  logic       w_regimm;
  logic       w_jmp;
  logic       w_jr;
  logic       w_unused_bits;

  assign w_op = i_instr[31:26];
  assign w_rt = i_instr[20:16];
  assign w_fn = i_instr[5:0];

  assign w_unused_bits = ^{i_instr[25:21],
                           i_instr[15:6]};

  assign w_br = (w_op[5:2] == OP_BR_HI);

  assign w_regimm = (w_op == OP_REGIMM) &&
                    ((w_rt == RT_BLTZ) ||
                     (w_rt == RT_BGEZ) ||
                     (w_rt == RT_BLTZAL) ||
                     (w_rt == RT_BGEZAL));

  assign w_jmp = (w_op == OP_J) ||
                 (w_op == OP_JAL);

  assign w_jr = (w_op == OP_SPECIAL) &&
                ((w_fn == FN_JR) ||
                 (w_fn == FN_JALR));

  always_comb begin
    o_is_bj = 1'b0;
    unique case (1'b1)
      w_br:     o_is_bj = 1'b1;
      w_regimm: o_is_bj = 1'b1;
      w_jmp:    o_is_bj = 1'b1;
      w_jr:     o_is_bj = 1'b1;
      default:  o_is_bj = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_inst_buffer.sv
// IF->ID fetch-packet FIFO with delay-slot tagging and WB flush.
// Optional zero-latency empty bypass: define ID_BUF_BYPASS_EN.
module id_inst_buffer
  import id_inst_buffer_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PTR_W    = $clog2(DEPTH),
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_in,
  input  logic               if_valid_in,
  output logic               buf_allowin_out,
  input  logic [PC_W-1:0]    if_PC_in,
  input  logic [INSTR_W-1:0] if_Instruct_in,
  input  logic               if_exception_in,
  input  logic [EXC_W-1:0]   if_ExcCode_in,
  input  logic [PC_W-1:0]    if_error_VAddr_in,
  input  logic               id_allowin_in,
  output logic               buf_valid_out,
  output logic [PC_W-1:0]    buf_PC_out,
  output logic [PC_W-1:0]    buf_NPC_out,
  output logic [PC_W-1:0]    buf_NNPC_out,
  output logic [INSTR_W-1:0] buf_Instruct_out,
  output logic               buf_exception_out,
  output logic [EXC_W-1:0]   buf_ExcCode_out,
  output logic [PC_W-1:0]    buf_error_VAddr_out,
  output logic               buf_bd_out,
  output logic [PTR_W:0]     buf_count_out
);

  localparam logic [PTR_W:0] ONE = 1;

  pkt_t             r_mem [DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic [PTR_W:0]   r_count;
  logic             r_bj_last;

  logic             w_full;
  logic             w_empty;
  logic             w_byp;
  logic             w_push;
  logic             w_pop;
  logic             w_wr;
  logic             w_rd;
  logic             w_is_bj;
  pkt_t             w_in;
  pkt_t             w_head;

  bj_predecode u_bj_predecode (
    .i_instr (if_Instruct_in),
    .o_is_bj (w_is_bj)
  );

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W-1:0] ==
                    r_rptr[PTR_W-1:0]) &&
                   (r_wptr[PTR_W] != r_rptr[PTR_W]);

  assign w_in = '{pc:      if_PC_in,
                  instr:   if_Instruct_in,
                  exc:     if_exception_in,
                  exccode: if_ExcCode_in,
                  vaddr:   if_error_VAddr_in,
                  bd:      r_bj_last};

`ifdef ID_BUF_BYPASS_EN
  assign w_byp = (r_count == '0) &&
                 if_valid_in && !flush_in;
`else
  assign w_byp = 1'b0;
`endif

  assign buf_allowin_out = !w_full ||
                           id_allowin_in ||
                           flush_in;
  assign buf_valid_out   = !w_empty || w_byp;

  assign w_push = if_valid_in &&
                  buf_allowin_out && !flush_in;
  assign w_pop  = buf_valid_out &&
                  id_allowin_in && !flush_in;

  // A bypassed packet taken by ID is never stored.
  assign w_wr = w_push && !(w_byp && id_allowin_in);
  assign w_rd = w_pop && !w_byp;

  assign w_head = w_byp ? w_in :
                  r_mem[r_rptr[PTR_W-1:0]];

  always_comb begin
    buf_PC_out          = RESET_PC;
    buf_Instruct_out    = '0;
    buf_exception_out   = 1'b0;
    buf_ExcCode_out     = '0;
    buf_error_VAddr_out = '0;
    buf_bd_out          = 1'b0;
    if (buf_valid_out) begin
      buf_PC_out          = w_head.pc;
      buf_Instruct_out    = w_head.instr;
      buf_exception_out   = w_head.exc;
      buf_ExcCode_out     = w_head.exccode;
      buf_error_VAddr_out = w_head.vaddr;
      buf_bd_out          = w_head.bd;
    end
  end

  assign buf_NPC_out   = buf_PC_out + 32'd4;
  assign buf_NNPC_out  = buf_PC_out + 32'd8;
  assign buf_count_out = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_bj_last <= 1'b0;
    end else if (flush_in) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_bj_last <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + ONE;
      if (w_rd)
        r_rptr <= r_rptr + ONE;
      if (w_wr && !w_rd)
        r_count <= r_count + ONE;
      else if (w_rd && !w_wr)
        r_count <= r_count - ONE;
      if (w_push)
        r_bj_last <= w_is_bj && !if_exception_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wptr[PTR_W-1:0]] <= w_in;
    end
  end

endmodule

// File: tb/tb_id_inst_buffer.sv
// Directed self-checking bench for id_inst_buffer.
// Covers fill/drain, full push+pop, bd tags, flush, exceptions, reset.
module tb_id_inst_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_in;
  logic        if_valid_in;
  logic        buf_allowin_out;
  logic [31:0] if_PC_in;
  logic [31:0] if_Instruct_in;
  logic        if_exception_in;
  logic [4:0]  if_ExcCode_in;
  logic [31:0] if_error_VAddr_in;
  logic        id_allowin_in;
  logic        buf_valid_out;
  logic [31:0] buf_PC_out;
  logic [31:0] buf_NPC_out;
  logic [31:0] buf_NNPC_out;
  logic [31:0] buf_Instruct_out;
  logic        buf_exception_out;
  logic [4:0]  buf_ExcCode_out;
  logic [31:0] buf_error_VAddr_out;
  logic        buf_bd_out;
  logic [2:0]  buf_count_out;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] BEQ  = 32'h1022_0003;
  localparam logic [31:0] ADDU = 32'h0022_1821;
  localparam logic [31:0] JR31 = 32'h03E0_0008;

  id_inst_buffer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_in            (flush_in),
    .if_valid_in         (if_valid_in),
    .buf_allowin_out     (buf_allowin_out),
    .if_PC_in            (if_PC_in),
    .if_Instruct_in      (if_Instruct_in),
    .if_exception_in     (if_exception_in),
    .if_ExcCode_in       (if_ExcCode_in),
    .if_error_VAddr_in   (if_error_VAddr_in),
    .id_allowin_in       (id_allowin_in),
    .buf_valid_out       (buf_valid_out),
    .buf_PC_out          (buf_PC_out),
    .buf_NPC_out         (buf_NPC_out),
    .buf_NNPC_out        (buf_NNPC_out),
    .buf_Instruct_out    (buf_Instruct_out),
    .buf_exception_out   (buf_exception_out),
    .buf_ExcCode_out     (buf_ExcCode_out),
    .buf_error_VAddr_out (buf_error_VAddr_out),
    .buf_bd_out          (buf_bd_out),
    .buf_count_out       (buf_count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] pc,
                       input logic [31:0] ins);
    if_valid_in       = v;
    if_PC_in          = pc;
    if_Instruct_in    = ins;
    if_exception_in   = 1'b0;
    if_ExcCode_in     = 5'd0;
    if_error_VAddr_in = 32'd0;
  endtask

  initial begin
    rst_n         = 1'b0;
    flush_in      = 1'b0;
    id_allowin_in = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    #12;
    rst_n = 1'b1;
    #1;
    chk("rst_valid", {31'd0, buf_valid_out}, 32'd0);
    chk("rst_allow", {31'd0, buf_allowin_out}, 32'd1);
    chk("rst_count", {29'd0, buf_count_out}, 32'd0);
    chk("rst_pc", buf_PC_out, 32'hBFC0_0000);
    chk("rst_npc", buf_NPC_out, 32'hBFC0_0004);
    chk("rst_nnpc", buf_NNPC_out, 32'hBFC0_0008);
    chk("rst_instr", buf_Instruct_out, 32'd0);

    // fill four entries with ID stalled
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), ADDU);
      step();
    end
    drive(1'b0, 32'd0, 32'd0);
    #1;
    chk("full_count", {29'd0, buf_count_out}, 32'd4);
    chk("full_allow", {31'd0, buf_allowin_out}, 32'd0);
    chk("full_head", buf_PC_out, 32'h100);

    // full: simultaneous push and pop
    id_allowin_in = 1'b1;
    drive(1'b1, 32'h110, ADDU);
    #1;
    chk("pp_allow", {31'd0, buf_allowin_out}, 32'd1);
    step();
    drive(1'b0, 32'd0, 32'd0);
    #1;
    chk("pp_count", {29'd0, buf_count_out}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", buf_PC_out, 32'h104 + 32'(4 * i));
      step();
    end
    chk("drain_count", {29'd0, buf_count_out}, 32'd0);
    chk("drain_valid", {31'd0, buf_valid_out}, 32'd0);
    chk("drain_pc_rst", buf_PC_out, 32'hBFC0_0000);

    // delay-slot tag across a bubble
    id_allowin_in = 1'b0;
    drive(1'b1, 32'h200, BEQ);
    step();
    drive(1'b0, 32'd0, 32'd0);
    step();
    step();
    drive(1'b1, 32'h204, ADDU);
    step();
    drive(1'b1, 32'h208, ADDU);
    step();
    drive(1'b0, 32'd0, 32'd0);
    id_allowin_in = 1'b1;
    #1;
    chk("bd0_pc", buf_PC_out, 32'h200);
    chk("bd0", {31'd0, buf_bd_out}, 32'd0);
    step();
    chk("bd1_pc", buf_PC_out, 32'h204);
    chk("bd1", {31'd0, buf_bd_out}, 32'd1);
    step();
    chk("bd2_pc", buf_PC_out, 32'h208);
    chk("bd2", {31'd0, buf_bd_out}, 32'd0);
    step();

    // jr $31 tags its successor
    id_allowin_in = 1'b0;
    drive(1'b1, 32'h300, JR31);
    step();
    drive(1'b1, 32'h304, ADDU);
    step();
    drive(1'b0, 32'd0, 32'd0);
    id_allowin_in = 1'b1;
    #1;
    chk("jr_bd", {31'd0, buf_bd_out}, 32'd0);
    step();
    chk("jr_next_pc", buf_PC_out, 32'h304);
    chk("jr_next_bd", {31'd0, buf_bd_out}, 32'd1);
    step();

    // flush with three queued and bj_last set
    id_allowin_in = 1'b0;
    drive(1'b1, 32'h400, BEQ);
    step();
    drive(1'b1, 32'h404, ADDU);
    step();
    drive(1'b1, 32'h408, BEQ);
    step();
    chk("fl_count3", {29'd0, buf_count_out}, 32'd3);
    drive(1'b1, 32'h40C, ADDU);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    #1;
    chk("fl_count", {29'd0, buf_count_out}, 32'd0);
    chk("fl_valid", {31'd0, buf_valid_out}, 32'd0);
    drive(1'b1, 32'h500, ADDU);
    step();
    drive(1'b0, 32'd0, 32'd0);
    #1;
    chk("fl_next_pc", buf_PC_out, 32'h500);
    chk("fl_next_bd", {31'd0, buf_bd_out}, 32'd0);
    id_allowin_in = 1'b1;
    step();
    id_allowin_in = 1'b0;

    // exception packet with a branch word
    drive(1'b1, 32'h600, BEQ);
    if_exception_in   = 1'b1;
    if_ExcCode_in     = 5'd4;
    if_error_VAddr_in = 32'h201;
    step();
    drive(1'b1, 32'h604, ADDU);
    step();
    drive(1'b1, 32'hFFFF_FFFC, ADDU);
    step();
    drive(1'b0, 32'd0, 32'd0);
    id_allowin_in = 1'b1;
    #1;
    chk("exc_flag", {31'd0, buf_exception_out}, 32'd1);
    chk("exc_code", {27'd0, buf_ExcCode_out}, 32'd4);
    chk("exc_vaddr", buf_error_VAddr_out, 32'h201);
    step();
    chk("exc_next_bd", {31'd0, buf_bd_out}, 32'd0);
    chk("exc_next_flag", {31'd0, buf_exception_out}, 32'd0);
    step();
    chk("wrap_pc", buf_PC_out, 32'hFFFF_FFFC);
    chk("wrap_npc", buf_NPC_out, 32'h0000_0000);
    chk("wrap_nnpc", buf_NNPC_out, 32'h0000_0004);
    step();

    // asynchronous reset mid-cycle
    id_allowin_in = 1'b0;
    drive(1'b1, 32'h700, ADDU);
    step();
    drive(1'b1, 32'h704, BEQ);
    step();
    drive(1'b0, 32'd0, 32'd0);
    chk("ar_count2", {29'd0, buf_count_out}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, buf_valid_out}, 32'd0);
    chk("ar_count", {29'd0, buf_count_out}, 32'd0);
    chk("ar_pc", buf_PC_out, 32'hBFC0_0000);
    chk("ar_allow", {31'd0, buf_allowin_out}, 32'd1);
    step();
    rst_n = 1'b1;
    step();

`ifdef ID_BUF_BYPASS_EN
    id_allowin_in = 1'b1;
    drive(1'b1, 32'h300, ADDU);
    #1;
    chk("byp_valid", {31'd0, buf_valid_out}, 32'd1);
    chk("byp_pc", buf_PC_out, 32'h300);
    step();
    drive(1'b0, 32'd0, 32'd0);
    #1;
    chk("byp_count", {29'd0, buf_count_out}, 32'd0);
    chk("byp_empty", {31'd0, buf_valid_out}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_inst_buffer.md
Name: id_inst_buffer

Overview:
- Parametrised IF→ID decoupling queue.
- It replaces the single-entry IF/ID pipeline register with a DEPTH-entry FIFO of fetch packets (PC, instruction, fetch exception info).
- It uses the same valid/allowin handshake on both sides.
- It adds an exact branch-delay-slot (bd) tag per entry, computed at push time from a predecode of the previously pushed instruction, and a single-cycle flush driven by the writeback exception/eret redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width; internal pointers are PTR_W+1 bits (wrap bit).
- RESET_PC, 32'hBFC0_0000, PC value driven on buf_PC_out when empty.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_in  in  1  redirect from WB (ClrStpJmp); empties queue
- if_valid_in  in  1  IF packet valid
- buf_allowin_out  out  1  queue can accept a packet this cycle
- if_PC_in  in  32  fetch PC
- if_Instruct_in  in  32  fetched instruction
- if_exception_in  in  1  fetch exception flag
- if_ExcCode_in  in  5  fetch ExcCode
- if_error_VAddr_in  in  32  bad virtual address
- id_allowin_in  in  1  ID accepts head this cycle
- buf_valid_out  out  1  head packet valid
- buf_PC_out  out  32  head PC
- buf_NPC_out  out  32  head PC+4
- buf_NNPC_out  out  32  head PC+8
- buf_Instruct_out  out  32  head instruction
- buf_exception_out  out  1  head exception flag
- buf_ExcCode_out  out  5  head ExcCode
- buf_error_VAddr_out  out  32  head bad VAddr
- buf_bd_out  out  1  head is in a delay slot
- buf_count_out  out  PTR_W+1  occupancy, 0..DEPTH

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: all pointers 0, count 0, bj_last 0, all slot storage 0.
  - Outputs after reset: buf_valid_out=0, buf_allowin_out=1, buf_count_out=0.
  - Data outputs after reset: PC=RESET_PC, NPC=RESET_PC+4, NNPC=RESET_PC+8, all other data outputs 0.
- Push and pop:
  - push = if_valid_in & buf_allowin_out & !flush_in.
  - pop = buf_valid_out & id_allowin_in & !flush_in.
- Allowin: buf_allowin_out = (count<DEPTH) | id_allowin_in | flush_in.
  - When full, a simultaneous push and pop is legal.
  - The combinational path from id_allowin_in to buf_allowin_out is accepted.
- Valid: buf_valid_out = (count!=0).
  - Default latency is 1 cycle: a packet pushed at edge N is visible at the head after edge N.
- Ordering: strict FIFO. Write pointer and read pointer advance by 1 modulo 2·DEPTH.
  - Full is defined as: low bits equal and wrap bits differ.
  - Empty is defined as: pointers equal.
- Count update per edge:
  - push & !pop: +1.
  - pop & !push: −1.
  - both or neither: unchanged.
- Empty output: while buf_valid_out=0, data outputs show the reset values listed above, not stale slot contents.
- NPC/NNPC arithmetic: PC+4 and PC+8 are computed from the head PC, modulo 2^32.
- bd tag:
  - On each push, the entry's bd bit = bj_last.
  - bj_last is then updated to is_bj(if_Instruct_in) & !if_exception_in.
  - bj_last is updated only on push; it holds across bubbles and stalls.
- is_bj is true for:
  - opcode 000100–000111;
  - opcode 000001 with rt ∈ {00000, 00001, 10000, 10001};
  - opcode 000010 and 000011;
  - opcode 000000 with funct 001000 or 001001.
- Flush:
  - At the edge where flush_in=1: pointers, count and bj_last are set to 0.
  - Any push or pop presented in that cycle is discarded.
  - In the following cycle buf_valid_out=0.
- Reset mid-operation: asynchronous; all state clears immediately, regardless of push, pop or flush.

Optional Feature:
- Macro: ID_BUF_BYPASS_EN.
- Defined: when count==0 and if_valid_in=1 and flush_in=0:
  - The incoming packet drives the head outputs combinationally, with buf_bd_out=bj_last and buf_valid_out=1.
  - If id_allowin_in=1 the packet is consumed without being written; count and pointers are unchanged, and bj_last is still updated.
  - Otherwise the packet is written normally.
  - Latency is 0.
- Undefined: latency is 1 cycle and buf_valid_out depends only on registered state.

Decomposition:
- Shared defines header holds:
  - fetch-packet field widths (PC 32, instr 32, ExcCode 5);
  - RESET_PC;
  - opcode and funct constants for the branch/jump classes.
- One sub-module, bj_predecode: combinational, 32-bit instruction in, is_bj out.
  - It is reusable by the decoder's brcal selection.
- Slot storage is a flat register array inside id_inst_buffer.

Test Plan:
- Fill and drain, DEPTH=4, id_allowin_in=0: push PCs 0x100, 0x104, 0x108, 0x10C → count=4, buf_allowin_out=0. Then id_allowin_in=1 for 4 cycles → heads pop in order 0x100..0x10C, final count=0, buf_valid_out=0, buf_PC_out=0xBFC00000.
- Full with simultaneous push and pop: full queue, id_allowin_in=1, push PC 0x110 → buf_allowin_out=1, count stays 4, 0x110 emerges fifth.
- Delay-slot tag: push beq (0x10220003) at 0x200, a 2-cycle bubble, then addu at 0x204, then addu at 0x208 → bd bits are 0, 1, 0. Repeat with jr $31 (0x03E00008) → next entry bd=1.
- Flush: with 3 entries queued and bj_last=1, pulse flush_in while if_valid_in=1 → next cycle count=0, buf_valid_out=0; the next pushed entry has bd=0.
- Exception entry: push a packet with if_exception_in=1, ExcCode=4, VAddr 0x00000201, instruction word = beq encoding → head carries exception=1, ExcCode=4, VAddr 0x201; the following entry has bd=0.
- Asynchronous reset: assert rst_n=0 mid-cycle with 2 entries queued → outputs take reset values immediately, without waiting for a clock edge. With ID_BUF_BYPASS_EN defined, on an empty queue push PC 0x300 with id_allowin_in=1 → buf_valid_out=1 in the same cycle and count stays 0.
